// File: rtl/amam_pd_pkg.sv
// Shared types, constants and helpers for the AM/AM predistorter datapath.
// Samples are signed 16-bit rails; gains are unsigned Q2.14 words.
package amam_pd_pkg;

    typedef logic signed [15:0] sample_t;
    typedef logic [15:0]        gain_t;

    localparam int GAIN_FRAC  = 14;
    localparam int UNITY_GAIN = 16384;
    localparam int ROUND_HALF = 8192;
    localparam int SAT_MAX    = 32767;
    localparam int SAT_MIN    = -32768;

    typedef enum logic [0:0] {IDLE, SWAP} bank_state_t;

    // Magnitude on 15 bits; the most negative code clamps so it cannot wrap to zero.
    function automatic logic [14:0] abs_clamp(input sample_t x);
        if (x == sample_t'(SAT_MIN)) begin
            return 15'h7fff;
        end else if (x[15]) begin
            return 15'(-x);
        end else begin
            return x[14:0];
        end
    endfunction

endpackage

// File: rtl/amam_gain_lut.sv
// Double-banked gain table: one write port into the shadow bank and two
// registered read ports (I and Q), each with its own bank select.
module amam_gain_lut
    import amam_pd_pkg::*;
#(
    parameter int unsigned LUT_AW = 8,
    parameter int unsigned GAIN_W = 16
) (
    input  logic              clk,
    input  logic              active_bank,
    input  logic              wr_en,
    input  logic [LUT_AW-1:0] wr_addr,
    input  logic [GAIN_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic              rd_i_bank,
    input  logic [LUT_AW-1:0] rd_i_addr,
    output logic [GAIN_W-1:0] rd_i_data,
    input  logic              rd_q_bank,
    input  logic [LUT_AW-1:0] rd_q_addr,
    output logic [GAIN_W-1:0] rd_q_data
);

    localparam int unsigned DEPTH = 2 ** (LUT_AW + 1);

    // Bank number is the MSB of the physical address.
    logic [GAIN_W-1:0] mem [DEPTH];
    logic [GAIN_W-1:0] rd_i_data_q;
    logic [GAIN_W-1:0] rd_q_data_q;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[{~active_bank, wr_addr}] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_i_data_q <= mem[{rd_i_bank, rd_i_addr}];
            rd_q_data_q <= mem[{rd_q_bank, rd_q_addr}];
        end
    end

    assign rd_i_data = rd_i_data_q;
    assign rd_q_data = rd_q_data_q;

endmodule

// File: rtl/amam_predistorter.sv
// AM/AM predistorter: y = x * g(|x|) per rail, 4-cycle streaming pipeline with
// a host-loaded double-banked gain table and a two-state bank-swap controller.
module amam_predistorter
    import amam_pd_pkg::*;
#(
    parameter int unsigned LUT_AW = 8,
    parameter int unsigned GAIN_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    input  logic signed [15:0] i_in,
    input  logic signed [15:0] q_in,
    input  logic               bypass,
    input  logic               lut_wr_en,
    input  logic [LUT_AW-1:0]  lut_wr_addr,
    input  logic [GAIN_W-1:0]  lut_wr_data,
    input  logic               swap_req,
    output logic               swap_ack,
    output logic               lut_loaded,
    output logic               out_valid,
    output logic signed [15:0] i_out,
    output logic signed [15:0] q_out
);

    localparam int unsigned PROD_W = GAIN_W + 17;
    localparam int unsigned SUM_W  = PROD_W + 1;

    typedef logic signed [PROD_W-1:0] prod_t;
    typedef logic signed [SUM_W-1:0]  sum_t;

    // Round half up at the Q2.14 binary point, then clamp to the sample range.
    function automatic sample_t round_sat(input prod_t p);
        sum_t r;
        r = (SUM_W'(p) + SUM_W'(ROUND_HALF)) >>> GAIN_FRAC;
        if (r > SUM_W'(SAT_MAX)) begin
            return sample_t'(SAT_MAX);
        end
        if (r < SUM_W'(SAT_MIN)) begin
            return sample_t'(SAT_MIN);
        end
        return r[15:0];
    endfunction

    // ---------------- bank control ----------------
    bank_state_t state_q, state_d;
    logic        bank_sel_q;
    logic        lut_loaded_q;
    logic        flip;

    always_comb begin
        state_d = state_q;
        flip    = 1'b0;
        case (state_q)
            IDLE: begin
                if (swap_req) begin
                    state_d = SWAP;
                end
            end
            SWAP: begin
                state_d = IDLE;
                flip    = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            bank_sel_q   <= 1'b0;
            lut_loaded_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (flip) begin
                bank_sel_q   <= ~bank_sel_q;
                lut_loaded_q <= 1'b1;
            end
        end
    end

    assign swap_ack   = flip;
    assign lut_loaded = lut_loaded_q;

    // ---------------- valid pipeline ----------------
    logic s1_valid_q, s2_valid_q, s3_valid_q, out_valid_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s3_valid_q <= 1'b0;
        end else begin
            s1_valid_q <= in_valid;
            s2_valid_q <= s1_valid_q;
            s3_valid_q <= s2_valid_q;
        end
    end

    // ---------------- S1: capture sample, bank and effective bypass ----------------
    sample_t s1_i_q, s1_q_q;
    logic    s1_bank_q, s1_bypass_q;

    always_ff @(posedge clk) begin
        if (in_valid) begin
            s1_i_q      <= i_in;
            s1_q_q      <= q_in;
            s1_bank_q   <= bank_sel_q;
            s1_bypass_q <= bypass | ~lut_loaded_q;
        end
    end

    logic [14:0]       abs_i, abs_q;
    logic [LUT_AW-1:0] idx_i, idx_q;

    always_comb begin
        abs_i = abs_clamp(s1_i_q);
        abs_q = abs_clamp(s1_q_q);
        idx_i = LUT_AW'(abs_i >> (15 - LUT_AW));
        idx_q = LUT_AW'(abs_q >> (15 - LUT_AW));
    end

    // ---------------- S2: registered table read ----------------
    logic [GAIN_W-1:0] lut_i, lut_q;

    amam_gain_lut #(
        .LUT_AW (LUT_AW),
        .GAIN_W (GAIN_W)
    ) u_gain_lut (
        .clk         (clk),
        .active_bank (bank_sel_q),
        .wr_en       (lut_wr_en),
        .wr_addr     (lut_wr_addr),
        .wr_data     (lut_wr_data),
        .rd_en       (s1_valid_q),
        .rd_i_bank   (s1_bank_q),
        .rd_i_addr   (idx_i),
        .rd_i_data   (lut_i),
        .rd_q_bank   (s1_bank_q),
        .rd_q_addr   (idx_q),
        .rd_q_data   (lut_q)
    );

    sample_t s2_i_q, s2_q_q;
    logic    s2_bypass_q;

    always_ff @(posedge clk) begin
        if (s1_valid_q) begin
            s2_i_q      <= s1_i_q;
            s2_q_q      <= s1_q_q;
            s2_bypass_q <= s1_bypass_q;
        end
    end

    logic [GAIN_W-1:0] gain_i, gain_q;

    always_comb begin
        gain_i = s2_bypass_q ? GAIN_W'(UNITY_GAIN) : lut_i;
        gain_q = s2_bypass_q ? GAIN_W'(UNITY_GAIN) : lut_q;
    end

    // ---------------- S3: signed x unsigned product ----------------
    prod_t prod_i_q, prod_q_q;

    always_ff @(posedge clk) begin
        if (s2_valid_q) begin
            prod_i_q <= PROD_W'(s2_i_q) * PROD_W'($signed({1'b0, gain_i}));
            prod_q_q <= PROD_W'(s2_q_q) * PROD_W'($signed({1'b0, gain_q}));
        end
    end

    // ---------------- S4: round, saturate, register ----------------
    sample_t i_out_q, q_out_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            i_out_q     <= '0;
            q_out_q     <= '0;
        end else begin
            out_valid_q <= s3_valid_q;
            if (s3_valid_q) begin
                i_out_q <= round_sat(prod_i_q);
                q_out_q <= round_sat(prod_q_q);
            end
        end
    end

    assign out_valid = out_valid_q;
    assign i_out     = i_out_q;
    assign q_out     = q_out_q;

endmodule

// File: doc/amam_predistorter.md
Name: amam_predistorter

Overview:
- Synthesizable AM/AM predistorter placed ahead of the I/Q compression stage on the TX path. It applies a per-rail memoryless expansion gain so that the downstream amplitude compression is cancelled.
- Each rail is processed as y = x * g(|x|). The gain g comes from a host-loaded, double-banked lookup table.
- Fixed-latency streaming pipeline with valid qualifiers and no backpressure.

Parameters:
- LUT_AW, 8, LUT address width. The table has 2^LUT_AW gain entries, shared by the I and Q rails.
- GAIN_W, 16, width of an unsigned gain word, format Q2.14. Unity is 16384; maximum is about 4.0.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  input sample strobe
- i_in  in  16  signed in-phase input
- q_in  in  16  signed quadrature input
- bypass  in  1  forces unity gain; sampled alongside each input sample
- lut_wr_en  in  1  shadow-bank write strobe
- lut_wr_addr  in  LUT_AW  shadow-bank entry address
- lut_wr_data  in  GAIN_W  gain written to the shadow bank
- swap_req  in  1  single-cycle pulse: make the shadow bank active
- swap_ack  out  1  single-cycle pulse on the cycle the banks swap
- lut_loaded  out  1  high once at least one swap has completed since reset
- out_valid  out  1  output sample strobe
- i_out  out  16  signed predistorted in-phase output
- q_out  out  16  signed predistorted quadrature output

Behaviour:
- Reset (synchronous):
  - out_valid, i_out, q_out, swap_ack and lut_loaded all go to 0.
  - The active bank select goes to 0.
  - Pipeline valid bits are cleared; samples in flight are discarded.
  - LUT RAM contents are not reset and remain undefined until written.
- Pipeline: fixed 4 cycles from an in_valid sample to its out_valid. Gaps in in_valid propagate as gaps in out_valid.
  - S1: register x, in_valid, the bank select, and the effective bypass (bypass OR NOT lut_loaded).
    - abs = |x|, with -32768 clamped to 32767.
    - idx = abs[14 -: LUT_AW], i.e. abs[14:7] at the default LUT_AW.
  - S2: registered LUT read of idx from the bank captured in S1. If effective bypass is set, gain = 16384.
  - S3: signed product p = x * $signed({1'b0, gain}), 17x16 into 33 bits.
  - S4: r = (p + 8192) >>> 14 (round half up), then saturate to [-32768, 32767] and register.
- Unity gain is bit-exact: x*16384 rounds back to x, so bypass and an unloaded table give an exact 4-cycle pass-through.
- I and Q are processed independently. There is no cross-rail amplitude term.
- Bank control is a 2-state FSM, IDLE and SWAP. No other states exist.
  - IDLE: on swap_req, go to SWAP.
  - SWAP (one cycle): flip the active bank, pulse swap_ack, set lut_loaded = 1, return to IDLE.
  - A swap_req arriving while in SWAP is ignored, with no ack. Minimum spacing between swap_req pulses is 2 cycles.
- Each sample uses the bank latched in S1 for its entire life. A swap never mixes banks within a sample or between the I and Q of one sample.
- A sample accepted on the swap cycle itself uses the old bank.
- Writes always target the currently inactive (shadow) bank.
- A write in the same cycle as swap_req, or in the SWAP cycle, lands in the bank that is shadow before the flip. That bank becomes active after the flip.
- Writes never disturb the active bank, so host loading is safe while samples stream.
- lut_loaded falls only on reset.

Decomposition:
- Package amam_pd_pkg holds:
  - sample_t (logic signed [15:0]) and gain_t;
  - GAIN_FRAC = 14 and UNITY_GAIN = 16384;
  - ROUND_HALF = 8192, SAT_MAX = 32767 and SAT_MIN = -32768;
  - the FSM enum bank_state_t {IDLE, SWAP}.
- Sub-module amam_gain_lut: two banks of 2^LUT_AW x GAIN_W.
  - One write port, always directed to the shadow bank.
  - Two registered read ports (I and Q), each with its own per-port bank select.
  - Maps to block RAM.

Test Plan:
- Pass-through: after reset, with no swap, i_in=1234 and q_in=-32768 -> 4 cycles later out_valid=1, i_out=1234, q_out=-32768; lut_loaded=0.
- Unity table: write 16384 to all entries, swap -> swap_ack pulses once and lut_loaded=1. Then i_in=-20000 -> i_out=-20000 with latency 4.
- Expansion and saturation: entry 156 = 32768 (2.0) and entry 0 = 24576 (1.5).
  - i_in=20000 (idx 156) -> i_out=32767.
  - i_in=-20000 -> i_out=-32768.
  - q_in=3 (idx 0) -> 4.5, rounds to q_out=5.
- Rounding: gain 20000, x=-1 -> p=-20000, (p+8192)>>>14 = -1. Gain 8192, x=1 -> 1 (0.5 rounds up).
- Bank isolation and swap timing: active table = 16384, shadow = 32768, continuous in_valid with x=1000 while swap_req pulses.
  - Samples accepted up to and including the swap cycle -> 1000.
  - Samples accepted after the swap cycle -> 2000.
  - Writes issued mid-stream never alter outputs before the swap.
- Mid-stream reset: reset asserted with 3 samples in flight -> next cycle out_valid=0, i_out=0, lut_loaded=0.
  - After release, outputs are pass-through.
  - A back-to-back swap_req during SWAP yields exactly one swap_ack.
